load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle data-memory responder for the 8-bit core's save/load path (ALU_op 111).
- Accepts a request carrying address, store data (from the register file's save_out) and destination register index.
- Owns an internal byte-wide data memory and applies programmable wait states.
- On loads, returns the data and a one-cycle write-enable pulse in the form the register file consumes (write data, 3-bit destination index, write strobe).

Parameters:
ADDR_W, 4, data-memory address width; memory depth is 2**ADDR_W bytes
WAIT_CYCLES, 2, cycles spent in ACCESS before the memory operation commits; legal range 1..15

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present; sampled only when idle
req_is_load  input  1  1 = load, 0 = store
req_addr  input  ADDR_W  byte address
req_store_data  input  8  store data
req_dest  input  3  destination register index for loads
busy  output  1  unit not idle; requests ignored while high
done  output  1  one-cycle pulse when a request completes (load or store)
wb_valid  output  1  one-cycle register-write strobe, loads only
wb_data  output  8  loaded byte
wb_reg  output  3  destination register index for wb_data

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, every memory byte=0. busy=0, done=0, wb_valid=0, wb_data=0, wb_reg=0. Reset mid-request aborts it. An uncommitted store is discarded. No done/wb_valid is produced for an aborted request.
- States: IDLE, ACCESS, RESP. All outputs are registered or decoded from state only. There is no combinational path from any req_* input to any output.
- IDLE:
  - On an edge with req_valid=1, latch is_load/addr/store_data/dest, load counter with WAIT_CYCLES, go to ACCESS.
  - With req_valid=0, stay in IDLE.
- ACCESS:
  - Each edge decrements the counter.
  - On the edge where counter==1, commit: a store writes mem[addr]=store_data; a load captures mem[addr] into wb_data and dest into wb_reg.
  - The same edge moves to RESP.
- RESP: lasts exactly one cycle. done=1, and wb_valid=1 only if the request was a load. The next edge returns to IDLE.
- busy = (state != IDLE).
- Timing, with E0 the accepting edge:
  - busy is high for cycles 1..WAIT_CYCLES+1.
  - done and wb_valid are high in cycle WAIT_CYCLES+1.
  - The earliest next accept is edge E(WAIT_CYCLES+2).
  - Throughput is one request per WAIT_CYCLES+2 cycles.
- req_valid while busy is ignored: no queueing, no error flag. The requester must hold the request until it sees busy=0 at an edge.
- Request inputs may change freely after acceptance; only the latched copies are used.
- wb_data and wb_reg hold their last load values until the next load commits. Stores never modify them.
- Address wraps naturally at ADDR_W bits; there is no out-of-range condition.
- A load following a store to the same address returns the stored byte, because the store commits before its RESP.
- wb_reg is passed through unmodified, including index 0. The register file decides writability.

Test Plan:
- Reset, then sample outputs -> busy=0, done=0, wb_valid=0, wb_data=0x00, wb_reg=0. A load from any address returns 0x00.
- WAIT_CYCLES=2: store 0xA5 to addr 3 at E0 -> busy high cycles 1-3, done high cycle 3 only, wb_valid stays 0. A following load addr 3, dest 5 -> wb_valid pulse in cycle 3 of that request with wb_data=0xA5, wb_reg=5.
- Back-to-back: hold req_valid=1 continuously with alternating store 0x11@2 / load @2 -> accepts spaced exactly 4 edges apart (WAIT_CYCLES+2). Load returns 0x11. Requests presented while busy are not executed.
- Change req_addr/req_store_data during ACCESS (store 0x3C@7, then drive 0xFF@8) -> mem[7]=0x3C, mem[8] unchanged (verify by loads).
- Assert rst in ACCESS of a store 0x77@1 -> outputs 0 immediately, no done pulse. A later load @1 returns 0x00.
- WAIT_CYCLES=1, ADDR_W=4: load from addr 15 after a store 0x5A@15 -> done in cycle 2. wb_data=0x5A. Previous wb_data/wb_reg held unchanged across an intervening store.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle data-memory responder for the 8-bit core's save/load path.
//   A request (address, store data, destination register) is latched when the
//   unit is idle, spends WAIT_CYCLES cycles in ACCESS, commits on the last of
//   those edges, then spends one cycle in RESP, where done pulses. For loads,
//   wb_valid also pulses in RESP, alongside wb_data/wb_reg, in the form the
//   register file consumes.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid           request present; sampled only while idle
//   req_is_load         1 = load, 0 = store
//   req_addr            byte address (ADDR_W bits, wraps naturally)
//   req_store_data      byte to store
//   req_dest            destination register index for loads
//   busy                unit not idle; requests ignored while high
//   done                one-cycle pulse on completion of any request
//   wb_valid            one-cycle register-write strobe, loads only
//   wb_data, wb_reg     last loaded byte and its destination index (held)
module load_store_unit #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_is_load,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_store_data,
  input  logic [2:0]        req_dest,
  output logic              busy,
  output logic              done,
  output logic              wb_valid,
  output logic [7:0]        wb_data,
  output logic [2:0]        wb_reg
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state;
  logic [3:0]        count;
  logic              lat_is_load;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_data;
  logic [2:0]        lat_dest;
  logic [7:0]        mem [DEPTH];

  // busy/done/wb_valid are registered copies of the state decode, so they are
  // set on the edge that enters the corresponding state and cleared on the edge
  // that leaves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      lat_is_load <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_dest    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_reg      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_is_load <= req_is_load;
            lat_addr    <= req_addr;
            lat_data    <= req_store_data;
            lat_dest    <= req_dest;
            count       <= 4'(WAIT_CYCLES);
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            if (lat_is_load) begin
              wb_data <= mem[lat_addr];
              wb_reg  <= lat_dest;
            end else begin
              mem[lat_addr] <= lat_data;
            end
            done     <= 1'b1;
            wb_valid <= lat_is_load;
            state    <= RESP;
          end
        end
        RESP: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit. Two instances: dut0 with
//   WAIT_CYCLES=2 and dut1 with WAIT_CYCLES=1 (both ADDR_W=4). They share the
//   request fields and have separate req_valid lines; sel chooses which
//   instance's outputs are observed. A reference memory per instance provides
//   the expected load data.
module tb_load_store_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       rv0, rv1;
  logic       req_is_load;
  logic [3:0] req_addr;
  logic [7:0] req_store_data;
  logic [2:0] req_dest;

  logic       busy0, done0, wbv0, busy1, done1, wbv1;
  logic [7:0] wbd0, wbd1;
  logic [2:0] wbr0, wbr1;

  logic       sel;
  logic       o_busy, o_done, o_wbv;
  logic [7:0] o_wbd;
  logic [2:0] o_wbr;

  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_wbv  = sel ? wbv1  : wbv0;
  assign o_wbd  = sel ? wbd1  : wbd0;
  assign o_wbr  = sel ? wbr1  : wbr0;

  load_store_unit #(.ADDR_W(4), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_is_load(req_is_load),
    .req_addr(req_addr), .req_store_data(req_store_data), .req_dest(req_dest),
    .busy(busy0), .done(done0), .wb_valid(wbv0), .wb_data(wbd0), .wb_reg(wbr0)
  );

  load_store_unit #(.ADDR_W(4), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_is_load(req_is_load),
    .req_addr(req_addr), .req_store_data(req_store_data), .req_dest(req_dest),
    .busy(busy1), .done(done1), .wb_valid(wbv1), .wb_data(wbd1), .wb_reg(wbr1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: memory contents and held write-back values per instance.
  logic [7:0] mem_m [2][16];
  logic [7:0] exp_wd [2];
  logic [2:0] exp_wr [2];

  typedef struct {
    logic       is_load;
    logic [3:0] addr;
    logic [7:0] data;
    logic [2:0] dest;
    logic [7:0] exp_data;
    logic [3:0] post_addr;
    logic [7:0] post_data;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) mem_m[s][i] = 8'h00;
      exp_wd[s] = 8'h00;
      exp_wr[s] = 3'd0;
    end
  endtask

  // Issue one request to the selected instance and check every cycle until it
  // is idle again. Called just after a negedge; returns just after a negedge.
  task automatic do_req(input logic s, input logic is_load, input logic [3:0] addr,
                        input logic [7:0] data, input logic [2:0] dest,
                        input logic [7:0] exp_data, input logic [3:0] post_addr,
                        input logic [7:0] post_data);
    int w;
    int n;
    w   = s ? 1 : 2;
    sel = s;
    n   = 0;
    #1;
    while (o_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) begin
      chk("idle_wait_timeout", 1, 0);
      return;
    end
    req_is_load    = is_load;
    req_addr       = addr;
    req_store_data = data;
    req_dest       = dest;
    if (s) rv1 = 1'b1; else rv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Inputs may change freely after acceptance.
    rv0            = 1'b0;
    rv1            = 1'b0;
    req_addr       = post_addr;
    req_store_data = post_data;
    req_dest       = 3'($urandom);
    req_is_load    = 1'($urandom);
    for (int c = 1; c <= w + 1; c++) begin
      if (c > 1) @(negedge clk);
      chk("busy_during", int'(o_busy), 1);
      chk("done_timing", int'(o_done), (c == w + 1) ? 1 : 0);
      chk("wb_valid_timing", int'(o_wbv), (c == w + 1 && is_load) ? 1 : 0);
      if (c == w + 1 && is_load) begin
        chk("wb_data_load", int'(o_wbd), int'(exp_data));
        chk("wb_reg_load", int'(o_wbr), int'(dest));
      end else begin
        chk("wb_data_held", int'(o_wbd), int'(exp_wd[s]));
        chk("wb_reg_held", int'(o_wbr), int'(exp_wr[s]));
      end
    end
    @(negedge clk);
    chk("busy_after", int'(o_busy), 0);
    chk("done_after", int'(o_done), 0);
    chk("wb_valid_after", int'(o_wbv), 0);
    if (is_load) begin
      exp_wd[s] = mem_m[s][addr];
      exp_wr[s] = dest;
    end else begin
      mem_m[s][addr] = data;
    end
  endtask

  task automatic check_zero_outputs(input logic s);
    sel = s;
    #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_wb_valid", int'(o_wbv), 0);
    chk("rst_wb_data", int'(o_wbd), 0);
    chk("rst_wb_reg", int'(o_wbr), 0);
  endtask

  task automatic b2b_drive(input int k);
    req_is_load    = (k % 2) == 1;
    req_addr       = 4'd2;
    req_store_data = (k < 2) ? 8'h11 : 8'h22;
    req_dest       = (k < 2) ? 3'd1 : 3'd2;
  endtask

  // Hold req_valid continuously with alternating store/load to address 2.
  task automatic back_to_back();
    int  k, edge_n, last_edge, dn, lw;
    logic idle;
    logic [7:0] bexp_d [2];
    logic [2:0] bexp_r [2];
    bexp_d[0] = 8'h11; bexp_r[0] = 3'd1;
    bexp_d[1] = 8'h22; bexp_r[1] = 3'd2;
    k = 0; edge_n = 0; last_edge = 0; dn = 0; lw = 0;
    sel = 1'b0;
    b2b_drive(0);
    rv0 = 1'b1;
    while (k < 4 && edge_n < 100) begin
      idle = !o_busy;
      @(posedge clk);
      edge_n++;
      if (idle) begin
        if (k > 0) chk("b2b_spacing", edge_n - last_edge, 4);
        last_edge = edge_n;
        k++;
      end
      @(negedge clk);
      if (o_done) dn++;
      if (o_wbv) begin
        if (lw < 2) begin
          chk("b2b_wb_data", int'(o_wbd), int'(bexp_d[lw]));
          chk("b2b_wb_reg", int'(o_wbr), int'(bexp_r[lw]));
        end
        lw++;
      end
      if (idle) begin
        if (k < 4) b2b_drive(k);
        else rv0 = 1'b0;
      end
    end
    rv0 = 1'b0;
    chk("b2b_accepts", k, 4);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o_done) dn++;
      if (o_wbv) begin
        if (lw < 2) begin
          chk("b2b_wb_data", int'(o_wbd), int'(bexp_d[lw]));
          chk("b2b_wb_reg", int'(o_wbr), int'(bexp_r[lw]));
        end
        lw++;
      end
    end
    chk("b2b_done_count", dn, 4);
    chk("b2b_load_count", lw, 2);
    mem_m[0][2] = 8'h22;
    exp_wd[0]   = 8'h22;
    exp_wr[0]   = 3'd2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       s, ld;
    logic [3:0] a;
    logic [7:0] d;
    logic [2:0] r;

    //             is_load addr   data   dest  exp    post_a post_d
    vecs[0] = '{1'b1, 4'd0,  8'h00, 3'd4, 8'h00, 4'd9, 8'h5E};
    vecs[1] = '{1'b0, 4'd3,  8'hA5, 3'd0, 8'h00, 4'd3, 8'h00};
    vecs[2] = '{1'b1, 4'd3,  8'h00, 3'd5, 8'hA5, 4'd0, 8'h00};
    vecs[3] = '{1'b0, 4'd7,  8'h3C, 3'd0, 8'h00, 4'd8, 8'hFF};
    vecs[4] = '{1'b1, 4'd8,  8'h00, 3'd6, 8'h00, 4'd7, 8'h00};
    vecs[5] = '{1'b1, 4'd7,  8'h00, 3'd1, 8'h3C, 4'd8, 8'h00};
    vecs[6] = '{1'b1, 4'd3,  8'h00, 3'd0, 8'hA5, 4'd1, 8'h00};
    vecs[7] = '{1'b0, 4'd2,  8'h11, 3'd7, 8'h00, 4'd5, 8'h99};
    vecs[8] = '{1'b1, 4'd2,  8'h00, 3'd2, 8'h11, 4'd2, 8'h00};
    vecs[9] = '{1'b1, 4'd15, 8'h00, 3'd7, 8'h00, 4'd0, 8'h00};

    sel = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
    req_is_load = 1'b0; req_addr = '0; req_store_data = '0; req_dest = '0;
    rst = 1'b1;
    reset_model();
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs(1'b0);
    check_zero_outputs(1'b1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_req(1'b0, vecs[i].is_load, vecs[i].addr, vecs[i].data, vecs[i].dest,
             vecs[i].exp_data, vecs[i].post_addr, vecs[i].post_data);
    end

    back_to_back();

    // Reset in the middle of a store's ACCESS phase.
    sel = 1'b0;
    req_is_load = 1'b0; req_addr = 4'd1; req_store_data = 8'h77; req_dest = 3'd3;
    rv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv0 = 1'b0;
    chk("abort_busy_before", int'(o_busy), 1);
    #2 rst = 1'b1;
    check_zero_outputs(1'b0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("abort_no_done", int'(o_done), 0);
      chk("abort_no_wb_valid", int'(o_wbv), 0);
    end
    do_req(1'b0, 1'b1, 4'd1, 8'h00, 3'd4, 8'h00, 4'd1, 8'h77);

    // WAIT_CYCLES=1 instance: held write-back across a store, top address.
    do_req(1'b1, 1'b0, 4'd4,  8'h99, 3'd0, 8'h00, 4'd4, 8'h00);
    do_req(1'b1, 1'b1, 4'd4,  8'h00, 3'd6, 8'h99, 4'd4, 8'h00);
    do_req(1'b1, 1'b0, 4'd15, 8'h5A, 3'd0, 8'h00, 4'd0, 8'h00);
    do_req(1'b1, 1'b1, 4'd15, 8'h00, 3'd3, 8'h5A, 4'd0, 8'h00);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      s  = (i % 3) == 0;
      ld = 1'($urandom);
      a  = 4'($urandom);
      d  = 8'($urandom);
      r  = 3'($urandom);
      do_req(s, ld, a, d, r, mem_m[s][a], 4'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
